// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Data-memory access sequencer for the RV32 load/store stage. Accepts one
// decoded request at a time (req_valid/req_ready), drives a word-wide bus with
// byte enables and returns a single-cycle response carrying the sign- or
// zero-extended load data or a fault flag.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_*                 request handshake, op (1=load), size, unsigned, addr, wdata
//   resp_valid/rdata/fault one-cycle completion pulse with load data and fault
//   bus_valid/ready       bus request handshake
//   bus_we/addr/be/wdata  word-aligned request fields, held until accepted
//   bus_rvalid/rdata      read return channel, honoured only while waiting
//
// Configuration
//   MEM_MISALIGNED_SPLIT_EN  when defined, misaligned half/word accesses that
//                            cross a word boundary are split into two bus
//                            accesses; otherwise every misaligned access faults.
//   TIMEOUT_CYCLES           cycles allowed per bus phase before a fault; 0 disables.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic        req_ready_q, req_ready_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;

    logic [3:0]  mask_s;
    logic [7:0]  be_sh_s;
    logic [63:0] wd_sh_s;
    logic        bad_s;
    logic        tick_s;
`ifdef MEM_MISALIGNED_SPLIT_EN
    logic        split_q, split_d;
    logic [3:0]  hi_be_q, hi_be_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
`endif

    // Shift raw bus data down to the access offset, truncate and extend.
    function automatic logic [31:0] load_extend(input logic [63:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'b00:   load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh[31:0];
        endcase
    endfunction

    // Lane mask, shifted enables/data and legality of the incoming request.
    always_comb begin
        case (req_size)
            2'b00:   mask_s = 4'b0001;
            2'b01:   mask_s = 4'b0011;
            2'b10:   mask_s = 4'b1111;
            default: mask_s = 4'b0000;
        endcase
        be_sh_s = {4'b0000, mask_s} << req_addr[1:0];
        wd_sh_s = {32'h00000000, req_wdata} << {req_addr[1:0], 3'b000};
`ifdef MEM_MISALIGNED_SPLIT_EN
        bad_s = (req_size == 2'b11);
`else
        bad_s = (req_size == 2'b11) ||
                ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
        tick_s = (TIMEOUT_CYCLES != 32'd0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);
    end

    // Next-state, captured-request and output-register computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
`ifdef MEM_MISALIGNED_SPLIT_EN
        split_d      = split_q;
        hi_be_d      = hi_be_q;
        hi_wdata_d   = hi_wdata_q;
        rdata0_d     = rdata0_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 32'd0;
                if (req_valid) begin
                    op_d   = req_op;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
`ifdef MEM_MISALIGNED_SPLIT_EN
                    split_d    = (be_sh_s[7:4] != 4'b0000);
                    hi_be_d    = be_sh_s[7:4];
                    hi_wdata_d = wd_sh_s[63:32];
`endif
                    if (bad_s) begin
                        state_d      = S_RESP;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = 32'h00000000;
                    end else begin
                        state_d     = S_REQ0;
                        bus_we_d    = ~req_op;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = be_sh_s[3:0];
                        bus_wdata_d = wd_sh_s[31:0];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ0: begin
                if (bus_ready) begin
                    cnt_d = 32'd0;
                    if (op_q) begin
                        state_d = S_WAIT0;
`ifdef MEM_MISALIGNED_SPLIT_EN
                    end else if (split_q) begin
                        state_d     = S_REQ1;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_be_d    = hi_be_q;
                        bus_wdata_d = hi_wdata_q;
`endif
                    end else begin
                        state_d      = S_RESP;
                        resp_fault_d = 1'b0;
                        resp_rdata_d = 32'h00000000;
                    end
                end else if (tick_s) begin
                    state_d      = S_RESP;
                    resp_fault_d = 1'b1;
                    resp_rdata_d = 32'h00000000;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT0: begin
                if (bus_rvalid) begin
                    cnt_d = 32'd0;
`ifdef MEM_MISALIGNED_SPLIT_EN
                    rdata0_d = bus_rdata;
                    if (split_q) begin
                        state_d    = S_REQ1;
                        bus_addr_d = bus_addr_q + 32'd4;
                        bus_be_d   = hi_be_q;
                    end else begin
                        state_d      = S_RESP;
                        resp_fault_d = 1'b0;
                        resp_rdata_d = load_extend({32'h00000000, bus_rdata}, off_q, size_q, uns_q);
                    end
`else
                    state_d      = S_RESP;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = load_extend({32'h00000000, bus_rdata}, off_q, size_q, uns_q);
`endif
                end else if (tick_s) begin
                    state_d      = S_RESP;
                    resp_fault_d = 1'b1;
                    resp_rdata_d = 32'h00000000;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`ifdef MEM_MISALIGNED_SPLIT_EN
            S_REQ1: begin
                if (bus_ready) begin
                    cnt_d = 32'd0;
                    if (op_q) begin
                        state_d = S_WAIT1;
                    end else begin
                        state_d      = S_RESP;
                        resp_fault_d = 1'b0;
                        resp_rdata_d = 32'h00000000;
                    end
                end else if (tick_s) begin
                    state_d      = S_RESP;
                    resp_fault_d = 1'b1;
                    resp_rdata_d = 32'h00000000;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT1: begin
                if (bus_rvalid) begin
                    cnt_d        = 32'd0;
                    state_d      = S_RESP;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = load_extend({bus_rdata, rdata0_q}, off_q, size_q, uns_q);
                end else if (tick_s) begin
                    state_d      = S_RESP;
                    resp_fault_d = 1'b1;
                    resp_rdata_d = 32'h00000000;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`endif
            S_RESP: begin
                cnt_d   = 32'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 32'd0;
                state_d = S_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        req_ready_d  = (state_d == S_IDLE);
        bus_valid_d  = (state_d == S_REQ0) || (state_d == S_REQ1);
        resp_valid_d = (state_d == S_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            op_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b1;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h00000000;
            bus_be_q     <= 4'b0000;
            bus_wdata_q  <= 32'h00000000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h00000000;
            resp_fault_q <= 1'b0;
`ifdef MEM_MISALIGNED_SPLIT_EN
            split_q      <= 1'b0;
            hi_be_q      <= 4'b0000;
            hi_wdata_q   <= 32'h00000000;
            rdata0_q     <= 32'h00000000;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
`ifdef MEM_MISALIGNED_SPLIT_EN
            split_q      <= split_d;
            hi_be_q      <= hi_be_d;
            hi_wdata_q   <= hi_wdata_d;
            rdata0_q     <= rdata0_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl. A byte-level reference
// model derives the expected bus accesses and load results from the access
// rules; a procedural bus responder inserts stalls and timeouts.
module tb_mem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_op, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks = 0;
    int failures = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One complete transaction; called at a negedge with the DUT idle.
    // d0/d1: bus_ready stall cycles per access; rv0/rv1: rvalid delay (>=1).
    task automatic run_txn(input logic op, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd0, input logic [31:0] rd1,
                           input int d0, input int d1, input int rv0, input int rv1);
        int n, nacc, w, d, rv;
        logic [1:0] off;
        logic [31:0] b, e_addr0, e_addr1, e_wd0, e_wd1, e_val, ea, ewd, rd;
        logic [3:0] e_be0, e_be1, ebe;
        logic [7:0] byt;
        logic illegal, nobus, exp_fault, done, k;

        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        illegal = (size == 2'd3);
        off = addr[1:0];
        e_be0 = 4'd0; e_be1 = 4'd0; e_wd0 = 32'd0; e_wd1 = 32'd0; e_val = 32'd0;
        e_addr0 = {addr[31:2], 2'b00};
        e_addr1 = e_addr0 + 32'd4;
        // Touched bytes: enables and load bytes gathered one byte address at a time.
        for (int i = 0; i < n; i++) begin
            b = addr + i;
            k = (b[31:2] != addr[31:2]);
            if (k) begin
                e_be1[b[1:0]] = 1'b1;
                byt = rd1[8*b[1:0] +: 8];
            end else begin
                e_be0[b[1:0]] = 1'b1;
                byt = rd0[8*b[1:0] +: 8];
            end
            e_val[8*i +: 8] = byt;
        end
        for (int i = n; i < 4; i++)
            e_val[8*i +: 8] = (!uns && n > 0 && e_val[8*n-1]) ? 8'hFF : 8'h00;
        // Store data: every wdata byte lands at byte position off+j of a 64-bit window.
        for (int j = 0; j < 4; j++) begin
            if (off + j < 4) e_wd0[8*(off+j) +: 8] = wdata[8*j +: 8];
            else             e_wd1[8*(off+j-4) +: 8] = wdata[8*j +: 8];
        end
`ifdef MEM_MISALIGNED_SPLIT_EN
        nobus = illegal;
        nacc  = (e_be1 != 4'd0) ? 2 : 1;
`else
        nobus = illegal || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
        nacc  = 1;
`endif
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        req_valid = 1'b1; req_op = op; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        // Scramble request inputs after acceptance: the DUT must use its captured copy.
        req_valid = 1'b0; req_op = $urandom; req_size = $urandom; req_unsigned = $urandom;
        req_addr = $urandom; req_wdata = $urandom;
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        exp_fault = nobus;
        done = nobus;
        if (nobus) check("bus_valid_fault", {31'd0, bus_valid}, 32'd0);
        for (int a = 0; a < nacc && !done; a++) begin
            ea  = a ? e_addr1 : e_addr0;
            ebe = a ? e_be1 : e_be0;
            ewd = a ? e_wd1 : e_wd0;
            d   = a ? d1 : d0;
            check("bus_valid_on", {31'd0, bus_valid}, 32'd1);
            check("bus_addr", bus_addr, ea);
            check("bus_be", {28'd0, bus_be}, {28'd0, ebe});
            check("bus_we", {31'd0, bus_we}, {31'd0, ~op});
            if (!op) check("bus_wdata", bus_wdata, ewd);
            w = 0;
            while (w < d && !done) begin
                bus_ready = 1'b0; bus_rvalid = $urandom; bus_rdata = $urandom;
                @(negedge clk);
                w++;
                if (w == T) begin
                    exp_fault = 1'b1; done = 1'b1;
                end else begin
                    check("hold_valid", {31'd0, bus_valid}, 32'd1);
                    check("hold_addr", bus_addr, ea);
                    check("hold_be", {28'd0, bus_be}, {28'd0, ebe});
                    if (!op) check("hold_wdata", bus_wdata, ewd);
                end
            end
            if (!done) begin
                bus_ready = 1'b1; bus_rvalid = 1'b0;
                @(negedge clk);
                bus_ready = 1'b0;
                if (op) begin
                    rv = a ? rv1 : rv0;
                    rd = a ? rd1 : rd0;
                    check("wait_bus_valid", {31'd0, bus_valid}, 32'd0);
                    w = 1;
                    while (!done) begin
                        if (w == T + 1) begin
                            exp_fault = 1'b1; done = 1'b1;
                        end else if (w == rv) begin
                            bus_rvalid = 1'b1; bus_rdata = rd;
                            @(negedge clk);
                            bus_rvalid = 1'b0;
                            break;
                        end else begin
                            check("wait_no_resp", {31'd0, resp_valid}, 32'd0);
                            @(negedge clk);
                            w++;
                        end
                    end
                end
            end
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_fault", {31'd0, resp_fault}, {31'd0, exp_fault});
        check("resp_rdata", resp_rdata, (op && !exp_fault) ? e_val : 32'd0);
        check("resp_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("resp_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
        check("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_fault"}, {31'd0, resp_fault}, 32'd0);
        check({tag, "_bus_valid"}, {31'd0, bus_valid}, 32'd0);
        check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
        check({tag, "_bus_addr"}, bus_addr, 32'd0);
        check({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80AA55CC, 32'h0, 0, 0, 1, 1);
        run_txn(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80AA55CC, 32'h0, 1, 0, 2, 1);
        run_txn(1'b0, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 32'h0, 3, 0, 1, 1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 1, 1);
        run_txn(1'b1, 2'd3, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 0, 0, 1, 1);
        run_txn(1'b1, 2'd2, 1'b0, 32'h401, 32'h0, 32'h11223344, 32'h55667788, 0, 0, 1, 1);
        run_txn(1'b1, 2'd2, 1'b0, 32'h0FFFFFFE, 32'h0, 32'hBBAA0000, 32'h0000DDCC, 0, 1, 1, 2);
        run_txn(1'b1, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0, 32'h0, 0, 0, 20, 1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h504, 32'h12345678, 32'h0, 32'h0, 9, 0, 1, 1);
        run_txn(1'b1, 2'd1, 1'b0, 32'h606, 32'h0, 32'h8001FFFF, 32'h0, 0, 0, T, 1);
        run_txn(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h0, 32'h0, T-1, T-1, 1, 1);

        // Randomized traffic, biased toward the top of the address space now and then.
        for (int t = 0; t < 300; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC | {30'd0, ra[1:0]};
            run_txn($urandom, $urandom, $urandom, ra, $urandom, $urandom, $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(1, 5), $urandom_range(1, 5));
        end

        // Reset asserted while waiting for read data.
        req_valid = 1'b1; req_op = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h700; bus_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        bus_ready = 1'b0;
        check("pre_reset_wait", {31'd0, bus_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_rvalid = $urandom; bus_rdata = $urandom;
            @(negedge clk);
            check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
            check("post_rst_ready", {31'd0, req_ready}, 32'd1);
            check("post_rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        end
        bus_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
